// File: rtl/rr_delay_scheduler.sv
// rr_delay_scheduler: round-robin owner of a single delay resource.
// Each requester holds req high. The winner owns the resource for len+1 RUN
// cycles and then gets a one-cycle done pulse. Dropping req while owning
// aborts the transaction with no done pulse.
// Ports:
//   clk    - clock, all state updates on posedge
//   rst_n  - asynchronous active-low reset
//   req    - per-requester level request
//   len    - per-requester delay length, requester i uses [i*CW +: CW]
//   grant  - one-hot current owner, zero when idle
//   done   - one-cycle completion pulse to the owner
//   busy   - high whenever the state is not IDLE
//   s      - current state encoding (IDLE=00, RUN=01, DONE=11)
module rr_delay_scheduler #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*CW-1:0] len,
   output logic [NREQ-1:0]    grant,
   output logic [NREQ-1:0]    done,
   output logic               busy,
   output logic [1:0]         s
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_ILL  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_count;
   logic [NREQ-1:0]   r_grant;
   logic [NREQ-1:0]   r_done;
   logic              r_busy;
   logic [IW-1:0]     r_last;

   state_t            w_next_state;
   logic [CW-1:0]     w_count;
   logic [NREQ-1:0]   w_grant;
   logic [NREQ-1:0]   w_done;
   logic [IW-1:0]     w_last;
   logic              w_win_found;
   logic [IW-1:0]     w_win_idx;
   logic [CW-1:0]     w_win_len;
   logic              w_owner_req;

   // Round-robin search starting one past the most recently granted index.
   always_comb begin
      int unsigned v_idx;
      v_idx       = 0;
      w_win_found = 1'b0;
      w_win_idx   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         v_idx = (32'(r_last) + k) % NREQ;
         if (!w_win_found && req[v_idx]) begin
            w_win_found = 1'b1;
            w_win_idx   = IW'(v_idx);
         end
      end
   end

   // len is sampled only here, at grant time.
   always_comb begin
      int unsigned v_base;
      v_base    = 32'(w_win_idx) * CW;
      w_win_len = len[v_base +: CW];
   end

   assign w_owner_req = |(req & r_grant);

   // Next-state and next-output logic.
   always_comb begin
      w_next_state = r_state;
      w_count      = r_count;
      w_grant      = r_grant;
      w_last       = r_last;
      w_done       = '0;
      case (r_state)
         ST_IDLE: begin
            w_count = '0;
            w_grant = '0;
            if (w_win_found) begin
               w_next_state = ST_RUN;
               w_grant      = NREQ'(1) << w_win_idx;
               w_count      = w_win_len;
               w_last       = w_win_idx;
            end
         end
         ST_RUN: begin
            if (!w_owner_req) begin
               // Abort: r_last keeps the aborted owner.
               w_next_state = ST_IDLE;
               w_grant      = '0;
               w_count      = '0;
            end else if (r_count != '0) begin
               w_count = r_count - CW'(1);
            end else begin
               w_next_state = ST_DONE;
               w_done       = r_grant;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
            w_grant      = '0;
            w_count      = '0;
         end
         default: begin
            w_next_state = ST_IDLE;
            w_grant      = '0;
            w_count      = '0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_grant <= '0;
         r_done  <= '0;
         r_busy  <= 1'b0;
         r_last  <= IW'(NREQ - 1);
      end else begin
         r_state <= w_next_state;
         r_count <= w_count;
         r_grant <= w_grant;
         r_done  <= w_done;
         r_busy  <= (w_next_state != ST_IDLE);
         r_last  <= w_last;
      end
   end

   assign grant = r_grant;
   assign done  = r_done;
   assign busy  = r_busy;
   assign s     = r_state;

endmodule

// File: tb/tb_rr_delay_scheduler.sv
// Bench for rr_delay_scheduler: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model.
module tb_rr_delay_scheduler;

   localparam int unsigned NREQ = 4;
   localparam int unsigned CW   = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] len;
   logic [NREQ-1:0]    grant;
   logic [NREQ-1:0]    done;
   logic               busy;
   logic [1:0]         s;

   rr_delay_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .len   (len),
      .grant (grant),
      .done  (done),
      .busy  (busy),
      .s     (s)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: owner index (-1 = none), RUN cycles left, done phase.
   int m_owner;
   int m_last;
   int m_left;
   bit m_done;

   // Observations collected per scenario.
   int         obs_busy;
   int         obs_done;
   int         obs_run;
   logic [3:0] obs_done_val;
   logic [1:0] prev_s;
   logic [3:0] grant_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = NREQ - 1;
      m_left  = 0;
      m_done  = 1'b0;
   endtask

   // Apply one posedge worth of behaviour using the inputs now being driven.
   task automatic model_edge();
      bit found;
      int idx;
      if (!rst_n) begin
         model_reset();
      end else if (m_done) begin
         m_done  = 1'b0;
         m_owner = -1;
      end else if (m_owner >= 0) begin
         if (!req[m_owner]) begin
            m_owner = -1;
         end else begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
         end
      end else begin
         found = 1'b0;
         for (int j = 1; j <= NREQ; j++) begin
            idx = (m_last + j) % NREQ;
            if (!found && req[idx]) begin
               found   = 1'b1;
               m_owner = idx;
               m_last  = idx;
               m_left  = int'((len >> (CW * idx)) & 16'hF) + 1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      logic [3:0] eg;
      logic [1:0] es;
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      es = (m_owner < 0) ? 2'b00 : (m_done ? 2'b11 : 2'b01);
      chk("grant", 32'(grant), 32'(eg));
      chk("done", 32'(done), m_done ? 32'(eg) : 32'd0);
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("s", 32'(s), 32'(es));
      chk("onehot0", 32'($onehot0(grant)), 32'd1);
      if (busy) obs_busy++;
      if (s == 2'b01) obs_run++;
      if (done != 0) begin
         obs_done++;
         obs_done_val = done;
      end
      if (s == 2'b01 && prev_s != 2'b01) grant_q.push_back(grant);
      prev_s = s;
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input logic [3:0] r, input logic [15:0] l);
      check_outputs();
      req = r;
      len = l;
      model_edge();
      @(negedge clk);
   endtask

   task automatic clear_obs();
      obs_busy     = 0;
      obs_done     = 0;
      obs_run      = 0;
      obs_done_val = '0;
      prev_s       = 2'b00;
      grant_q.delete();
   endtask

   // Asynchronous reset pulse asserted mid-cycle; outputs must clear at once.
   task automatic do_reset();
      check_outputs();
      rst_n = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      clear_obs();
   endtask

   logic [3:0]  r_rand;
   logic [15:0] l_rand;

   initial begin
      rst_n = 1'b0;
      req   = '0;
      len   = '0;
      model_reset();
      clear_obs();
      repeat (2) @(negedge clk);
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_s", 32'(s), 32'd0);
      rst_n = 1'b1;

      // Single request, len 14: 15 RUN cycles then one DONE cycle.
      do_reset();
      repeat (16) step(4'b0001, 16'h000E);
      repeat (4) step(4'b0000, 16'h0000);
      chk("single_busy_cycles", 32'(obs_busy), 32'd16);
      chk("single_done_pulses", 32'(obs_done), 32'd1);
      chk("single_done_val", 32'(obs_done_val), 32'h1);

      // Contention, all len 0, held: strict rotation starting at requester 0.
      do_reset();
      repeat (16) step(4'b1111, 16'h0000);
      repeat (3) step(4'b0000, 16'h0000);
      chk("rr_count_ge5", 32'(grant_q.size() >= 5), 32'd1);
      if (grant_q.size() >= 5) begin
         chk("rr_g0", 32'(grant_q[0]), 32'h1);
         chk("rr_g1", 32'(grant_q[1]), 32'h2);
         chk("rr_g2", 32'(grant_q[2]), 32'h4);
         chk("rr_g3", 32'(grant_q[3]), 32'h8);
         chk("rr_g4", 32'(grant_q[4]), 32'h1);
      end

      // Abort: drop req2 sampled at edge 5, then req0 must win over req2.
      do_reset();
      repeat (5) step(4'b0100, 16'h0A00);
      step(4'b0000, 16'h0A00);
      chk("abort_idle_s", 32'(s), 32'd0);
      step(4'b0000, 16'h0A00);
      step(4'b0101, 16'h0A03);
      chk("abort_rr_grant", 32'(grant), 32'h1);
      chk("abort_no_done", 32'(obs_done), 32'd0);
      repeat (3) step(4'b0000, 16'h0000);

      // len 0 boundary: one RUN plus one DONE cycle.
      do_reset();
      repeat (2) step(4'b0010, 16'h0000);
      repeat (3) step(4'b0000, 16'h0000);
      chk("len0_busy_cycles", 32'(obs_busy), 32'd2);
      chk("len0_done_pulses", 32'(obs_done), 32'd1);
      chk("len0_done_val", 32'(obs_done_val), 32'h2);

      // Reset mid-RUN, then a fresh full-length transaction.
      do_reset();
      repeat (7) step(4'b0001, 16'h000F);
      chk("midrun_no_done", 32'(obs_done), 32'd0);
      do_reset();
      repeat (17) step(4'b0001, 16'h000F);
      repeat (3) step(4'b0000, 16'h0000);
      chk("postrst_run_cycles", 32'(obs_run), 32'd16);
      chk("postrst_done_pulses", 32'(obs_done), 32'd1);

      // Randomized traffic with slowly changing requests and occasional resets.
      do_reset();
      r_rand = '0;
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < NREQ; b++)
            if ($urandom_range(7) == 0) r_rand[b] = ~r_rand[b];
         l_rand = 16'($urandom);
         if ($urandom_range(3) == 0) l_rand = l_rand & 16'h3333;
         if ($urandom_range(249) == 0) do_reset();
         else step(r_rand, l_rand);
      end
      check_outputs();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
